// File: rtl/lcd_pkg.sv
// Shared constants, types and colour mapping for the LCD timing generator.
package lcd_pkg;

    // Colour modes
    localparam int unsigned MODE_THRESH = 0;
    localparam int unsigned MODE_GREY   = 1;
    localparam int unsigned MODE_RGB332 = 2;

    // Default 800x480 panel timing
    localparam int unsigned DEF_H_ACTIVE  = 800;
    localparam int unsigned DEF_H_BP      = 182;
    localparam int unsigned DEF_H_FP      = 210;
    localparam int unsigned DEF_H_PULSE   = 1;
    localparam int unsigned DEF_V_ACTIVE  = 480;
    localparam int unsigned DEF_V_BP      = 0;
    localparam int unsigned DEF_V_FP      = 45;
    localparam int unsigned DEF_V_PULSE   = 5;
    localparam int unsigned DEF_FETCH_LAT = 2;

    // Width of the position counters and the x/y request ports
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tgen_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb_t;

    // Expand one 8-bit pixel into RGB565 according to the colour mode
    function automatic rgb_t map_colour(input logic [1:0] mode, input logic [7:0] d);
        rgb_t c;
        c = '0;
        case (mode)
            2'(MODE_THRESH): c = rgb_t'({16{d[7]}});
            2'(MODE_GREY): begin
                c.r = d[7:3];
                c.g = d[7:2];
                c.b = d[7:3];
            end
            2'(MODE_RGB332): begin
                c.r = {d[7:5], d[7:6]};
                c.g = {d[4:2], d[4:2]};
                c.b = {d[1:0], d[1:0], d[1]};
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_delay_line.sv
// Fixed-depth shift register used to align control signals with fetched pixels.
module lcd_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    if (DEPTH < 1 || WIDTH < 1) begin : g_param_check
        $fatal(1, "lcd_delay_line: WIDTH and DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock; reset empties the whole line
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: pixel request stage, fetch-latency alignment
// of DE/HSYNC/VSYNC and registered colour expansion.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_PULSE   = DEF_H_PULSE,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_PULSE   = DEF_V_PULSE,
    parameter int unsigned FETCH_LAT = DEF_FETCH_LAT,
    parameter int unsigned MODE      = MODE_THRESH,
    parameter int unsigned HS_POL    = 0,
    parameter int unsigned VS_POL    = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [7:0]       data,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             valid,
    output logic             sof,
    output logic [7:0]       frame,
    output logic             LCD_DE,
    output logic             LCD_HSYNC,
    output logic             LCD_VSYNC,
    output logic [4:0]       LCD_R,
    output logic [5:0]       LCD_G,
    output logic [4:0]       LCD_B
);

    localparam int unsigned H_TOTAL = H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_BP + V_ACTIVE + V_FP;
    localparam logic        HS_ACT  = (HS_POL != 0);
    localparam logic        VS_ACT  = (VS_POL != 0);

    if (H_PULSE >= H_TOTAL || V_PULSE >= V_TOTAL || FETCH_LAT > 7) begin : g_param_check
        $fatal(1, "lcd_timing_gen: illegal timing parameters");
    end

    tgen_state_e      state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [7:0]       frame_q, frame_d;
    logic             sof_q, sof_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [CNT_W-1:0] hx, vy;
    logic             run_d;

    logic [2:0]       pipe_q;
    logic             cap_en;
    rgb_t             col_q, col_d;

    // Raster position, frame counter and run/idle decision at frame wrap
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        frame_d = frame_q;
        sof_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (EN) begin
                    state_d = ST_RUN;
                    hcnt_d  = '0;
                    vcnt_d  = '0;
                    sof_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (hcnt_q == CNT_W'(H_TOTAL - 1)) begin
                    hcnt_d = '0;
                    if (vcnt_q == CNT_W'(V_TOTAL - 1)) begin
                        vcnt_d  = '0;
                        frame_d = frame_q + 8'd1;
                        if (EN) begin
                            sof_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        vcnt_d = vcnt_q + CNT_W'(1);
                    end
                end else begin
                    hcnt_d = hcnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request-stage decode of the next position; offsets wrap when before the porch
    always_comb begin
        run_d   = (state_d == ST_RUN);
        hx      = hcnt_d - CNT_W'(H_BP);
        vy      = vcnt_d - CNT_W'(V_BP);
        valid_d = run_d && (hx < CNT_W'(H_ACTIVE)) && (vy < CNT_W'(V_ACTIVE));
        x_d     = valid_d ? hx : '0;
        y_d     = valid_d ? vy : '0;
        hs_d    = run_d && (hcnt_d < CNT_W'(H_PULSE));
        vs_d    = run_d && (vcnt_d < CNT_W'(V_PULSE));
    end

    // Timing FSM with registered request-stage outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            frame_q <= '0;
            sof_q   <= 1'b0;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            frame_q <= frame_d;
            sof_q   <= sof_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    // DE/HS/VS follow the request stage by the fetch latency plus the colour register
    lcd_delay_line #(
        .WIDTH (3),
        .DEPTH (FETCH_LAT + 1)
    ) u_sync_dly (
        .clk_i  (CLK),
        .rst_i  (RST),
        .din_i  ({valid_q, hs_q, vs_q}),
        .dout_o (pipe_q)
    );

    // Capture strobe: a request's valid delayed to the clock its data arrives
    if (FETCH_LAT == 0) begin : g_cap_direct
        assign cap_en = valid_q;
    end else begin : g_cap_dly
        lcd_delay_line #(
            .WIDTH (1),
            .DEPTH (FETCH_LAT)
        ) u_cap_dly (
            .clk_i  (CLK),
            .rst_i  (RST),
            .din_i  (valid_q),
            .dout_o (cap_en)
        );
    end

    // Colour expansion, blanked outside the active window
    always_comb begin
        col_d = '0;
        if (cap_en) begin
            col_d = map_colour(2'(MODE), data);
        end
    end

    // Colour register, aligned with LCD_DE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    assign valid     = valid_q;
    assign x         = x_q;
    assign y         = y_q;
    assign sof       = sof_q;
    assign frame     = frame_q;
    assign LCD_DE    = pipe_q[2];
    assign LCD_HSYNC = pipe_q[1] ? HS_ACT : ~HS_ACT;
    assign LCD_VSYNC = pipe_q[0] ? VS_ACT : ~VS_ACT;
    assign LCD_R     = col_q.r;
    assign LCD_G     = col_q.g;
    assign LCD_B     = col_q.b;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench: three generators on a tiny 8x5 raster (grey / RGB332 with
// active-high syncs / threshold), sharing clock, reset, enable and data.
module tb_lcd_timing_gen;
    import lcd_pkg::*;

    localparam int FT  = 40;
    localparam int KX  = 0;   // data = requested x
    localparam int KFF = 1;   // data = 8'hFF
    localparam int KAE = 2;   // data = 8'b101_011_10
    localparam int K7F = 3;   // data = 8'h7F

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [7:0] data;

    logic [15:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic        a_valid, a_sof, a_de, a_hs, a_vs;
    logic        b_valid, b_sof, b_de, b_hs, b_vs;
    logic        c_valid, c_sof, c_de, c_hs, c_vs;
    logic [7:0]  a_frame, b_frame, c_frame;
    logic [4:0]  a_r, a_b, b_r, b_b, c_r, c_b;
    logic [5:0]  a_g, b_g, c_g;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_BP(2), .H_FP(2), .H_PULSE(1),
        .V_ACTIVE(3), .V_BP(1), .V_FP(1), .V_PULSE(1),
        .FETCH_LAT(2), .MODE(MODE_GREY), .HS_POL(0), .VS_POL(0)
    ) u_dut_a (
        .CLK(CLK), .RST(RST), .EN(EN), .data(data),
        .x(a_x), .y(a_y), .valid(a_valid), .sof(a_sof), .frame(a_frame),
        .LCD_DE(a_de), .LCD_HSYNC(a_hs), .LCD_VSYNC(a_vs),
        .LCD_R(a_r), .LCD_G(a_g), .LCD_B(a_b)
    );

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_BP(2), .H_FP(2), .H_PULSE(1),
        .V_ACTIVE(3), .V_BP(1), .V_FP(1), .V_PULSE(1),
        .FETCH_LAT(2), .MODE(MODE_RGB332), .HS_POL(1), .VS_POL(1)
    ) u_dut_b (
        .CLK(CLK), .RST(RST), .EN(EN), .data(data),
        .x(b_x), .y(b_y), .valid(b_valid), .sof(b_sof), .frame(b_frame),
        .LCD_DE(b_de), .LCD_HSYNC(b_hs), .LCD_VSYNC(b_vs),
        .LCD_R(b_r), .LCD_G(b_g), .LCD_B(b_b)
    );

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_BP(2), .H_FP(2), .H_PULSE(1),
        .V_ACTIVE(3), .V_BP(1), .V_FP(1), .V_PULSE(1),
        .FETCH_LAT(2), .MODE(MODE_THRESH), .HS_POL(0), .VS_POL(0)
    ) u_dut_c (
        .CLK(CLK), .RST(RST), .EN(EN), .data(data),
        .x(c_x), .y(c_y), .valid(c_valid), .sof(c_sof), .frame(c_frame),
        .LCD_DE(c_de), .LCD_HSYNC(c_hs), .LCD_VSYNC(c_vs),
        .LCD_R(c_r), .LCD_G(c_g), .LCD_B(c_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Raster position p = 8*line + column within one 40-clock frame
    function automatic bit req_act(input int p);
        if (p < 0) return 1'b0;
        return ((p % 8) >= 2) && ((p % 8) < 6) && ((p / 8) >= 1) && ((p / 8) < 4);
    endfunction

    function automatic bit req_hs(input int p);
        return (p >= 0) && ((p % 8) == 0);
    endfunction

    function automatic bit req_vs(input int p);
        return (p >= 0) && ((p / 8) == 0);
    endfunction

    // {check_enable, R, G, B} expected on DE for dut 0/1/2 and data kind
    function automatic logic [16:0] exp_col(input int d, input int kind);
        case (kind)
            KX:  return (d == 1) ? 17'h0 : {1'b1, 16'h0000};
            KFF: return {1'b1, 16'hFFFF};
            KAE: case (d)
                     0:       return {1'b1, 5'd21, 6'd43, 5'd21};
                     1:       return {1'b1, 5'b10110, 6'b011011, 5'b10101};
                     default: return {1'b1, 16'hFFFF};
                 endcase
            default: case (d)
                     0:       return {1'b1, 5'd15, 6'd31, 5'd15};
                     1:       return {1'b1, 5'd13, 6'd63, 5'd31};
                     default: return {1'b1, 16'h0000};
                 endcase
        endcase
    endfunction

    function automatic logic [7:0] data_for(input int kind, input int q);
        case (kind)
            KX:      return req_act(q) ? 8'((q % 8) - 2) : 8'h00;
            KFF:     return 8'hFF;
            KAE:     return 8'b101_011_10;
            default: return 8'h7F;
        endcase
    endfunction

    // Entered at clock 0 of a frame; checks clocks 0..stop_at-1 and advances
    task automatic run_frame(input int kind, input int drop_at, input int stop_at,
                             input logic [7:0] exp_frame);
        int          nv;
        int          nde;
        int          nhs;
        int          nvs;
        int          p;
        logic [16:0] e;
        nv = 0; nde = 0; nhs = 0; nvs = 0;
        for (int k = 0; k < stop_at; k++) begin
            p = k - 3;
            if (k == 0) check_eq("frame@sof", 32'(a_frame), 32'(exp_frame));
            check_eq($sformatf("valid k%0d", k), 32'(a_valid), 32'(req_act(k)));
            check_eq($sformatf("x k%0d", k), 32'(a_x), req_act(k) ? 32'((k % 8) - 2) : 32'h0);
            check_eq($sformatf("y k%0d", k), 32'(a_y), req_act(k) ? 32'((k / 8) - 1) : 32'h0);
            check_eq($sformatf("sof k%0d", k), 32'(a_sof), 32'(k == 0));
            check_eq($sformatf("de k%0d", k), 32'(a_de), 32'(req_act(p)));
            check_eq($sformatf("hs_a k%0d", k), 32'(a_hs), 32'(!req_hs(p)));
            check_eq($sformatf("vs_a k%0d", k), 32'(a_vs), 32'(!req_vs(p)));
            check_eq($sformatf("hs_b k%0d", k), 32'(b_hs), 32'(req_hs(p)));
            check_eq($sformatf("vs_b k%0d", k), 32'(b_vs), 32'(req_vs(p)));
            for (int d = 0; d < 3; d++) begin
                logic [15:0] got;
                got = (d == 0) ? {a_r, a_g, a_b} : (d == 1) ? {b_r, b_g, b_b} : {c_r, c_g, c_b};
                e = exp_col(d, kind);
                if (!req_act(p))
                    check_eq($sformatf("blank%0d k%0d", d, k), 32'(got), 32'h0);
                else if (e[16])
                    check_eq($sformatf("col%0d k%0d", d, k), 32'(got), 32'(e[15:0]));
            end
            nv  += int'(a_valid);
            nde += int'(a_de);
            nhs += int'(b_hs);
            nvs += int'(b_vs);
            data = data_for(kind, k - 2);
            if (k == drop_at) EN = 1'b0;
            tick();
        end
        if (stop_at == FT) begin
            check_eq("valid_count", 32'(nv), 32'd12);
            check_eq("de_count", 32'(nde), 32'd12);
            check_eq("hs_high_count", 32'(nhs), 32'd5);
            check_eq("vs_high_count", 32'(nvs), 32'd8);
        end
    endtask

    initial begin
        RST  = 1'b1;
        EN   = 1'b0;
        data = 8'h00;
        repeat (3) tick();

        // Outputs held in reset
        check_eq("rst valid", 32'(a_valid), 32'h0);
        check_eq("rst x", 32'(a_x), 32'h0);
        check_eq("rst y", 32'(a_y), 32'h0);
        check_eq("rst sof", 32'(a_sof), 32'h0);
        check_eq("rst de", 32'(a_de), 32'h0);
        check_eq("rst col", 32'({a_r, a_g, a_b}), 32'h0);
        check_eq("rst hs_a", 32'(a_hs), 32'h1);
        check_eq("rst vs_a", 32'(a_vs), 32'h1);
        check_eq("rst hs_b", 32'(b_hs), 32'h0);
        check_eq("rst vs_b", 32'(b_vs), 32'h0);
        check_eq("rst frame", 32'(a_frame), 32'h0);

        RST = 1'b0;
        tick();
        tick();
        check_eq("idle valid", 32'(a_valid), 32'h0);
        check_eq("idle sof", 32'(a_sof), 32'h0);

        // First frame with EN dropped mid-frame; data = x for grey check
        EN = 1'b1;
        tick();
        run_frame(KX, 15, FT, 8'd0);
        check_eq("park valid", 32'(a_valid), 32'h0);
        check_eq("park sof", 32'(a_sof), 32'h0);
        check_eq("park x", 32'(a_x), 32'h0);
        check_eq("park frame", 32'(a_frame), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("idle%0d valid", i), 32'(a_valid), 32'h0);
            check_eq($sformatf("idle%0d sof", i), 32'(a_sof), 32'h0);
        end
        check_eq("drained de", 32'(a_de), 32'h0);
        check_eq("drained hs_a", 32'(a_hs), 32'h1);
        check_eq("drained vs_b", 32'(b_vs), 32'h0);

        // Restart and run back-to-back frames through the colour patterns
        EN = 1'b1;
        tick();
        run_frame(KFF, -1, FT, 8'd1);
        run_frame(KAE, -1, FT, 8'd2);
        run_frame(K7F, -1, FT, 8'd3);
        run_frame(KAE, -1, 21, 8'd4);

        // Reset in the middle of an active line
        check_eq("pre-rst valid", 32'(a_valid), 32'h1);
        check_eq("pre-rst de", 32'(a_de), 32'h1);
        RST = 1'b1;
        #1;
        check_eq("mid-rst valid", 32'(a_valid), 32'h0);
        check_eq("mid-rst de", 32'(a_de), 32'h0);
        check_eq("mid-rst x", 32'(a_x), 32'h0);
        check_eq("mid-rst col_a", 32'({a_r, a_g, a_b}), 32'h0);
        check_eq("mid-rst col_b", 32'({b_r, b_g, b_b}), 32'h0);
        check_eq("mid-rst hs_a", 32'(a_hs), 32'h1);
        check_eq("mid-rst vs_b", 32'(b_vs), 32'h0);
        check_eq("mid-rst frame", 32'(a_frame), 32'h0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        run_frame(K7F, -1, FT, 8'd0);
        check_eq("post-rst frame", 32'(a_frame), 32'd1);
        check_eq("post-rst sof", 32'(a_sof), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
